uart_frame_streamer: RTL and testbench

- Parametrised successor to the periodic debug-dump transmitter.
- Snapshots a wide data word and serialises it over an internal 8N1 UART as a framed packet: optional header byte, DATA_WIDTH/8 payload bytes, optional checksum byte.
- Frames start either periodically (internal divider) or on an external trigger, with selectable byte order.
- Feeds the controller's UART RX path in benches, and feeds host-side debug links in hardware.

---
 rtl/uart_frame_streamer.sv | 149 ++++++++++++++
 tb/tb_uart_frame_streamer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_streamer.sv
// uart_frame_streamer: snapshots a wide word and sends it as an 8N1 UART
// frame (optional header byte, payload bytes, optional modulo-256 checksum).
// Frames start on an external trigger or from a free-running divider.
module uart_frame_streamer #(
    parameter int unsigned DATA_WIDTH              = 2080,
    parameter int unsigned BYTE_COUNT_WIDTH        = 9,
    parameter int unsigned UART_TICKS_PER_BIT      = 65,
    parameter int unsigned UART_TICKS_PER_BIT_SIZE = 7,
    parameter int unsigned DIVIDER_TICKS           = 727273,
    parameter int unsigned DIVIDER_TICKS_WIDTH     = 20,
    parameter bit          HEADER_EN               = 1'b1,
    parameter logic [7:0]  HEADER_BYTE             = 8'h7E,
    parameter bit          CHECKSUM_EN             = 1'b1,
    parameter bit          MSB_FIRST               = 1'b1
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  periodic_en,
    input  logic                  trigger,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  pending,
    output logic                  tx_out
);

    typedef enum logic [2:0] {IDLE, HEADER, DATA, CHECK, DONE} state_t;

    localparam logic [DIVIDER_TICKS_WIDTH-1:0]     DIV_LAST  = DIVIDER_TICKS_WIDTH'(DIVIDER_TICKS - 1);
    localparam logic [UART_TICKS_PER_BIT_SIZE-1:0] TICK_LAST = UART_TICKS_PER_BIT_SIZE'(UART_TICKS_PER_BIT - 1);
    localparam logic [BYTE_COUNT_WIDTH-1:0]        BYTE_LAST = BYTE_COUNT_WIDTH'(DATA_WIDTH / 8 - 1);
    localparam logic [3:0]                         STOP_BIT  = 4'd9;

    state_t                             state, state_next;
    logic [DATA_WIDTH-1:0]              shadow;
    logic [DIVIDER_TICKS_WIDTH-1:0]     div_cnt;
    logic [UART_TICKS_PER_BIT_SIZE-1:0] tick_cnt;
    logic [3:0]                         bit_idx;
    logic [BYTE_COUNT_WIDTH-1:0]        byte_idx;
    logic [7:0]                         cksum;
    logic [7:0]                         payload_byte;
    logic [7:0]                         cur_byte;
    logic                               in_byte;
    logic                               tick_last;
    logic                               byte_end;
    logic                               start_frame;
    logic                               request;

    assign in_byte      = (state == HEADER) || (state == DATA) || (state == CHECK);
    assign tick_last    = (tick_cnt == TICK_LAST);
    assign byte_end     = in_byte && tick_last && (bit_idx == STOP_BIT);
    assign payload_byte = MSB_FIRST ? shadow[DATA_WIDTH-1 -: 8] : shadow[7:0];
    assign request      = trigger || (periodic_en && (div_cnt == DIV_LAST));
    assign busy         = in_byte;
    assign frame_done   = (state == DONE);

    // Free-running divider; wraps whether or not periodic requests are enabled
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset)                 div_cnt <= '0;
        else if (div_cnt == DIV_LAST) div_cnt <= '0;
        else                        div_cnt <= div_cnt + 1'b1;
    end

    // Request latch: a new request wins over the clear caused by a frame start
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset)           pending <= 1'b0;
        else if (request)     pending <= 1'b1;
        else if (start_frame) pending <= 1'b0;
    end

    // FSM state register
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; DONE may launch the next frame directly
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (pending) begin
                    start_frame = 1'b1;
                    state_next  = HEADER_EN ? HEADER : DATA;
                end else begin
                    state_next  = IDLE;
                end
            end
            HEADER: if (byte_end) state_next = DATA;
            DATA: begin
                if (byte_end && (byte_idx == BYTE_LAST))
                    state_next = CHECKSUM_EN ? CHECK : DONE;
            end
            CHECK:   if (byte_end) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Bit/byte sequencing, snapshot shifting and checksum accumulation
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            shadow   <= '0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            cksum    <= '0;
        end else if (start_frame) begin
            shadow   <= data_in;
            tick_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            cksum    <= '0;
        end else if (in_byte) begin
            if (!tick_last) begin
                tick_cnt <= tick_cnt + 1'b1;
            end else begin
                tick_cnt <= '0;
                if (bit_idx != STOP_BIT) begin
                    bit_idx <= bit_idx + 4'd1;
                end else begin
                    bit_idx <= '0;
                    if (state == DATA) begin
                        cksum    <= cksum + payload_byte;
                        byte_idx <= byte_idx + 1'b1;
                        // the byte just sent is shifted out so the next one sits at the fixed tap
                        shadow   <= MSB_FIRST ? (shadow << 8) : (shadow >> 8);
                    end
                end
            end
        end
    end

    // Serial line: start bit, 8 data bits LSB first, stop bit; idle high
    always_comb begin
        case (state)
            DATA:    cur_byte = payload_byte;
            CHECK:   cur_byte = cksum;
            default: cur_byte = HEADER_BYTE;
        endcase
        tx_out = 1'b1;
        if (in_byte) begin
            if (bit_idx == 4'd0)          tx_out = 1'b0;
            else if (bit_idx >= STOP_BIT) tx_out = 1'b1;
            else                          tx_out = cur_byte[3'(bit_idx - 4'd1)];
        end
    end

endmodule

// File: tb/tb_uart_frame_streamer.sv
// Bench for uart_frame_streamer: three small configurations, a cycle model
// of the main instance built from the frame bit stream, and directed checks.
module tb_uart_frame_streamer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_a, data_b, data_c;
    logic        periodic_a;
    logic        trig_a, trig_b, trig_c;
    logic        busy_a, done_a, pend_a, tx_a;
    logic        busy_b, done_b, pend_b, tx_b;
    logic        busy_c, done_c, pend_c, tx_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_frame_streamer #(
        .DATA_WIDTH(16), .BYTE_COUNT_WIDTH(2), .UART_TICKS_PER_BIT(4),
        .UART_TICKS_PER_BIT_SIZE(3), .DIVIDER_TICKS(15), .DIVIDER_TICKS_WIDTH(4),
        .HEADER_EN(1'b1), .HEADER_BYTE(8'h7E), .CHECKSUM_EN(1'b1), .MSB_FIRST(1'b1)
    ) dut_a (
        .clk_in(clk), .reset(rst_n), .data_in(data_a), .periodic_en(periodic_a),
        .trigger(trig_a), .busy(busy_a), .frame_done(done_a), .pending(pend_a), .tx_out(tx_a)
    );

    uart_frame_streamer #(
        .DATA_WIDTH(16), .BYTE_COUNT_WIDTH(2), .UART_TICKS_PER_BIT(4),
        .UART_TICKS_PER_BIT_SIZE(3), .DIVIDER_TICKS(15), .DIVIDER_TICKS_WIDTH(4),
        .HEADER_EN(1'b1), .HEADER_BYTE(8'h7E), .CHECKSUM_EN(1'b1), .MSB_FIRST(1'b0)
    ) dut_b (
        .clk_in(clk), .reset(rst_n), .data_in(data_b), .periodic_en(1'b0),
        .trigger(trig_b), .busy(busy_b), .frame_done(done_b), .pending(pend_b), .tx_out(tx_b)
    );

    uart_frame_streamer #(
        .DATA_WIDTH(16), .BYTE_COUNT_WIDTH(2), .UART_TICKS_PER_BIT(4),
        .UART_TICKS_PER_BIT_SIZE(3), .DIVIDER_TICKS(15), .DIVIDER_TICKS_WIDTH(4),
        .HEADER_EN(1'b0), .HEADER_BYTE(8'h7E), .CHECKSUM_EN(1'b0), .MSB_FIRST(1'b1)
    ) dut_c (
        .clk_in(clk), .reset(rst_n), .data_in(data_c), .periodic_en(1'b0),
        .trigger(trig_c), .busy(busy_c), .frame_done(done_c), .pending(pend_c), .tx_out(tx_c)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Model of dut_a: a frame is a 160-sample line waveform built from its bytes
    localparam int FLEN = 160;
    logic m_line [0:FLEN-1];
    int   m_pos;
    int   m_div;
    bit   m_active, m_done, m_pending;

    always @(posedge clk or negedge rst_n) begin : model_a
        bit         req, start;
        logic [7:0] fb [0:3];
        if (!rst_n) begin
            m_active  = 1'b0;
            m_done    = 1'b0;
            m_pending = 1'b0;
            m_div     = 0;
            m_pos     = 0;
        end else begin
            req    = trig_a || (periodic_a && m_div == 14);
            start  = !m_active && m_pending;
            m_div  = (m_div == 14) ? 0 : m_div + 1;
            m_done = 1'b0;
            if (start) begin
                fb[0] = 8'h7E;
                fb[1] = data_a[15:8];
                fb[2] = data_a[7:0];
                fb[3] = fb[1] + fb[2];
                for (int b = 0; b < 4; b++)
                    for (int k = 0; k < 10; k++)
                        for (int t = 0; t < 4; t++)
                            m_line[b*40 + k*4 + t] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : fb[b][k-1];
                m_active = 1'b1;
                m_pos    = 0;
            end else if (m_active) begin
                m_pos++;
                if (m_pos == FLEN) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
            if (req)        m_pending = 1'b1;
            else if (start) m_pending = 1'b0;
        end
    end

    // Per-cycle comparison of dut_a against the model
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("model_tx",      {31'b0, tx_a},   {31'b0, m_active ? m_line[m_pos] : 1'b1});
            chk("model_busy",    {31'b0, busy_a}, {31'b0, m_active});
            chk("model_done",    {31'b0, done_a}, {31'b0, m_done});
            chk("model_pending", {31'b0, pend_a}, {31'b0, m_pending});
        end
    end

    // Captured outputs, index = instance (0=a, 1=b, 2=c)
    logic [2:0] cap_tx   [0:511];
    logic [2:0] cap_busy [0:511];
    logic [2:0] cap_done [0:511];
    logic [2:0] cap_pend [0:511];

    task automatic capture(input int n, input logic [2:0] who, input int t0, input int t1,
                           input int t2, input int t3, input int chg_at, input logic [15:0] chg_val);
        bit hit;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_tx[i]   = {tx_c, tx_b, tx_a};
            cap_busy[i] = {busy_c, busy_b, busy_a};
            cap_done[i] = {done_c, done_b, done_a};
            cap_pend[i] = {pend_c, pend_b, pend_a};
            hit    = (i == t0) || (i == t1) || (i == t2) || (i == t3);
            trig_a = who[0] && hit;
            trig_b = who[1] && hit;
            trig_c = who[2] && hit;
            if (i == chg_at) data_a = chg_val;
        end
    endtask

    // 10 line samples of one byte taken mid-bit; bit k of result = UART bit k
    function automatic logic [9:0] dec(input int inst, input int s);
        logic [9:0] r;
        for (int k = 0; k < 10; k++) r[k] = cap_tx[s + k*4 + 2][inst];
        return r;
    endfunction

    task automatic chk_bytes(input string nm, input int inst, input int s, input int nb, input logic [31:0] exp);
        logic [7:0] b;
        for (int j = 0; j < nb; j++) begin
            b = exp[31 - 8*j -: 8];
            chk($sformatf("%s_byte%0d", nm, j), {22'b0, dec(inst, s + j*40)}, {22'b0, 1'b1, b, 1'b0});
        end
    endtask

    function automatic int cnt(input int kind, input int inst, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) begin
            case (kind)
                0:       if (cap_busy[i][inst] == 1'b1) c++;
                1:       if (cap_done[i][inst] == 1'b1) c++;
                default: if (cap_tx[i][inst] == 1'b0) c++;
            endcase
        end
        return c;
    endfunction

    initial begin
        int s1;
        rst_n = 1'b1;
        trig_a = 1'b0; trig_b = 1'b0; trig_c = 1'b0;
        periodic_a = 1'b0;
        data_a = 16'hA55A; data_b = 16'hA55A; data_c = 16'h0102;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx_a", {31'b0, tx_a}, 1);     chk("rst_busy_a", {31'b0, busy_a}, 0);
        chk("rst_done_a", {31'b0, done_a}, 0); chk("rst_pend_a", {31'b0, pend_a}, 0);
        chk("rst_tx_b", {31'b0, tx_b}, 1);     chk("rst_busy_b", {31'b0, busy_b}, 0);
        chk("rst_done_b", {31'b0, done_b}, 0); chk("rst_pend_b", {31'b0, pend_b}, 0);
        chk("rst_tx_c", {31'b0, tx_c}, 1);     chk("rst_busy_c", {31'b0, busy_c}, 0);
        chk("rst_done_c", {31'b0, done_c}, 0); chk("rst_pend_c", {31'b0, pend_c}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single trigger to all three configurations
        capture(220, 3'b111, 0, -1, -1, -1, -1, 16'h0);
        chk("p1_pend_a", {31'b0, cap_pend[1][0]}, 1);
        chk("p1_tx_pre", {31'b0, cap_tx[1][0]}, 1);
        chk("p1_tx_start", {31'b0, cap_tx[2][0]}, 0);
        chk_bytes("p1_a", 0, 2, 4, 32'h7EA55AFF);
        chk_bytes("p1_b", 1, 2, 4, 32'h7E5AA5FF);
        chk_bytes("p1_c", 2, 2, 2, 32'h01020000);
        chk("p1_busy_a", cnt(0, 0, 220), 160);
        chk("p1_busy_b", cnt(0, 1, 220), 160);
        chk("p1_busy_c", cnt(0, 2, 220), 80);
        chk("p1_done_a", cnt(1, 0, 220), 1);
        chk("p1_done_b", cnt(1, 1, 220), 1);
        chk("p1_done_c", cnt(1, 2, 220), 1);

        // Three extra triggers during a frame coalesce into one more frame
        capture(360, 3'b001, 0, 20, 40, 60, -1, 16'h0);
        chk("p2_done_cnt", cnt(1, 0, 360), 2);
        chk("p2_busy_cnt", cnt(0, 0, 360), 320);
        chk("p2_gap_busy", {31'b0, cap_busy[162][0]}, 0);
        chk("p2_gap_tx", {31'b0, cap_tx[162][0]}, 1);
        chk("p2_gap_done", {31'b0, cap_done[162][0]}, 1);
        chk("p2_restart_tx", {31'b0, cap_tx[163][0]}, 0);
        chk_bytes("p2_f2", 0, 163, 4, 32'h7EA55AFF);
        chk("p2_pend_end", {31'b0, cap_pend[359][0]}, 0);

        // Periodic requests faster than a frame; data changes mid-frame
        periodic_a = 1'b1;
        capture(500, 3'b000, -1, -1, -1, -1, 100, 16'h1234);
        periodic_a = 1'b0;
        s1 = -1;
        for (int i = 0; i < 40; i++) if (s1 < 0 && cap_tx[i][0] == 1'b0) s1 = i;
        chk("p3_first_start", {31'b0, s1 >= 0}, 1);
        if (s1 >= 0) begin
            chk_bytes("p3_f1", 0, s1, 4, 32'h7EA55AFF);
            chk("p3_gap_busy", {31'b0, cap_busy[s1+160][0]}, 0);
            chk("p3_gap_tx", {31'b0, cap_tx[s1+160][0]}, 1);
            chk_bytes("p3_f2", 0, s1 + 161, 4, 32'h7E123446);
            chk("p3_f3_start", {31'b0, cap_tx[s1+322][0]}, 0);
        end
        for (int i = 0; i < 600 && (busy_a !== 1'b0 || pend_a !== 1'b0 || done_a !== 1'b0); i++)
            @(negedge clk);
        chk("p3_drain", {29'b0, busy_a, pend_a, done_a}, 0);

        // Reset during the payload aborts the frame at once
        data_a = 16'hF020;
        capture(70, 3'b001, 0, -1, -1, -1, -1, 16'h0);
        chk("p4_busy_before", {31'b0, cap_busy[69][0]}, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("p4_rst_tx", {31'b0, tx_a}, 1);
        chk("p4_rst_busy", {31'b0, busy_a}, 0);
        chk("p4_rst_pend", {31'b0, pend_a}, 0);
        chk("p4_rst_done", {31'b0, done_a}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        capture(50, 3'b000, -1, -1, -1, -1, -1, 16'h0);
        chk("p4_quiet_busy", cnt(0, 0, 50), 0);
        chk("p4_quiet_tx", cnt(2, 0, 50), 0);
        capture(200, 3'b001, 0, -1, -1, -1, -1, 16'h0);
        chk_bytes("p4_full", 0, 2, 4, 32'h7EF02010);
        chk("p4_busy_cnt", cnt(0, 0, 200), 160);
        chk("p4_done_cnt", cnt(1, 0, 200), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
